bus_dev_rx_port: RTL and testbench

Device-side receive port of the multi-drop bus: the delivering end of the bus handler's push path. The port watches the bus's `push`/`D_push` strobe and keeps only packets whose destination field matches this device's ID, or that carry the broadcast ID. Accepted packets are buffered in a FIFO. The device drains the FIFO through the same `pndng`/`pop`/`D_pop` handshake the bus uses on its transmit side. One instance sits on each of the DRVRS device drops.

---
 rtl/bus_dev_rx_port.sv | 124 ++++++++++++
 tb/tb_bus_dev_rx_port.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/bus_dev_rx_port.sv
// bus_dev_rx_port
// Device-side receive port of the multi-drop bus. Watches the bus push strobe,
// keeps packets addressed to this device (or broadcast, when enabled), and
// buffers them in a DEPTH-entry FIFO that the device drains with pop.
//
// Build option:
//   BUS_RX_BCAST_EN  when defined, packets whose destination equals BCAST_ID
//                    are accepted as hits; otherwise they are ignored.
//
// Ports:
//   clk       in   sole clock, rising edge
//   reset     in   synchronous, active-high
//   push      in   bus delivers D_push this cycle
//   D_push    in   packet; [BITS-1:BITS-8] destination ID, rest payload
//   pop       in   device consumes the head entry
//   D_pop     out  head entry (zeros when empty)
//   pndng     out  FIFO non-empty
//   full      out  count == DEPTH
//   count     out  number of stored entries
//   drop_cnt  out  addressed packets lost to a full FIFO, saturating at 255
//   misroute  out  sticky: a push carried an illegal, non-broadcast destination
module bus_dev_rx_port #(
  parameter int         BITS     = 16,
  parameter int         DRVRS    = 4,
  parameter logic [7:0] ID       = 8'd0,
  parameter int         DEPTH    = 8,
  parameter logic [7:0] BCAST_ID = 8'hFF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [BITS-1:0]          D_push,
  input  logic                     pop,
  output logic [BITS-1:0]          D_pop,
  output logic                     pndng,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic [7:0]               drop_cnt,
  output logic                     misroute
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [BITS-1:0] mem [DEPTH];

  logic [AW-1:0] wr_reg;
  logic [AW-1:0] rd_reg;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;
  logic          pndng_reg;
  logic          full_reg;
  logic [7:0]    drop_cnt_reg;
  logic          misroute_reg;

  logic [7:0] dest;
  logic       bcast_en;
  logic       hit;
  logic       pop_eff;
  logic       wr_en;
  logic       drop;
  logic       bad_dest;

`ifdef BUS_RX_BCAST_EN
  assign bcast_en = 1'b1;
`else
  assign bcast_en = 1'b0;
`endif

  assign dest    = D_push[BITS-1:BITS-8];
  assign hit     = push && ((dest == ID) || (bcast_en && (dest == BCAST_ID)));
  assign pop_eff = pop && pndng_reg;
  // A pop on a full FIFO frees the slot the same edge, so the write still lands.
  assign wr_en   = hit && (!full_reg || pop_eff);
  assign drop    = hit && full_reg && !pop_eff;
  // Misroute is judged on every push, whether or not it targets this port.
  assign bad_dest = push && (int'(dest) >= DRVRS) && (dest != BCAST_ID);

  always_comb begin
    count_next = count_reg;
    case ({wr_en, pop_eff})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_reg       <= '0;
      rd_reg       <= '0;
      count_reg    <= '0;
      pndng_reg    <= 1'b0;
      full_reg     <= 1'b0;
      drop_cnt_reg <= '0;
      misroute_reg <= 1'b0;
    end else begin
      if (wr_en)   wr_reg <= wr_reg + AW'(1);
      if (pop_eff) rd_reg <= rd_reg + AW'(1);
      count_reg <= count_next;
      pndng_reg <= (count_next != '0);
      full_reg  <= (count_next == CW'(DEPTH));
      if (drop && (drop_cnt_reg != 8'hFF)) drop_cnt_reg <= drop_cnt_reg + 8'd1;
      if (bad_dest) misroute_reg <= 1'b1;
    end
  end

  // Storage is not reset; each entry loads only when the write pointer selects it.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
      always_ff @(posedge clk) begin
        if (!reset && wr_en && (wr_reg == AW'(gi))) mem[gi] <= D_push;
      end
    end
  endgenerate

  assign D_pop    = pndng_reg ? mem[rd_reg] : '0;
  assign pndng    = pndng_reg;
  assign full     = full_reg;
  assign count    = count_reg;
  assign drop_cnt = drop_cnt_reg;
  assign misroute = misroute_reg;

endmodule

// File: tb/tb_bus_dev_rx_port.sv
// Testbench for bus_dev_rx_port with ID=2, DRVRS=4, DEPTH=8, BITS=16.
// Directed vectors with hand-computed expectations; a small queue tracks
// expected FIFO contents during the pointer-wrap sequence.
module tb_bus_dev_rx_port;

  logic        clk;
  logic        reset;
  logic        push;
  logic [15:0] D_push;
  logic        pop;
  logic [15:0] D_pop;
  logic        pndng;
  logic        full;
  logic [3:0]  count;
  logic [7:0]  drop_cnt;
  logic        misroute;

  int vectors;
  int miscompares;

  bus_dev_rx_port #(
    .BITS(16), .DRVRS(4), .ID(8'd2), .DEPTH(8), .BCAST_ID(8'hFF)
  ) dut (
    .clk(clk), .reset(reset), .push(push), .D_push(D_push), .pop(pop),
    .D_pop(D_pop), .pndng(pndng), .full(full), .count(count),
    .drop_cnt(drop_cnt), .misroute(misroute)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, then return inputs to idle 1 ns after the edge.
  task automatic step(input logic p, input logic [15:0] d, input logic pp, input logic r);
    push   = p;
    D_push = d;
    pop    = pp;
    reset  = r;
    @(posedge clk);
    #1;
    push   = 1'b0;
    D_push = 16'h0000;
    pop    = 1'b0;
    reset  = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_pndng"}, 32'(pndng), 32'd0);
    check({tag, "_full"}, 32'(full), 32'd0);
    check({tag, "_count"}, 32'(count), 32'd0);
    check({tag, "_drop"}, 32'(drop_cnt), 32'd0);
    check({tag, "_misroute"}, 32'(misroute), 32'd0);
    check({tag, "_dpop"}, 32'(D_pop), 32'd0);
  endtask

  logic [15:0] q[$];
  logic        do_pop;

  initial begin
    vectors = 0;
    miscompares = 0;
    push = 1'b0; D_push = '0; pop = 1'b0; reset = 1'b1;
    @(negedge clk);
    step(1'b0, 16'h0, 1'b0, 1'b1);
    step(1'b0, 16'h0, 1'b0, 1'b1);
    check_reset_state("reset");

    // Basic match / non-match.
    step(1'b1, 16'h0211, 1'b0, 1'b0);
    check("hit_pndng", 32'(pndng), 32'd1);
    check("hit_dpop", 32'(D_pop), 32'h0211);
    check("hit_count", 32'(count), 32'd1);
    step(1'b1, 16'h0122, 1'b0, 1'b0);
    check("nohit_count", 32'(count), 32'd1);
    check("nohit_dpop", 32'(D_pop), 32'h0211);
    check("nohit_misroute", 32'(misroute), 32'd0);
    step(1'b0, 16'h0, 1'b1, 1'b0);
    check("pop1_pndng", 32'(pndng), 32'd0);
    check("pop1_dpop", 32'(D_pop), 32'd0);

    // Pop while empty is ignored; hit+pop while empty still writes.
    step(1'b0, 16'h0, 1'b1, 1'b0);
    check("empty_pop_count", 32'(count), 32'd0);
    step(1'b1, 16'h0233, 1'b1, 1'b0);
    check("empty_hitpop_count", 32'(count), 32'd1);
    check("empty_hitpop_dpop", 32'(D_pop), 32'h0233);
    step(1'b0, 16'h0, 1'b1, 1'b0);
    check("empty_hitpop_drain", 32'(count), 32'd0);

    // Fill and overflow.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 16'h0200 + 16'(i), 1'b0, 1'b0);
      check($sformatf("fill%0d_count", i), 32'(count), 32'(i + 1));
    end
    check("fill_full", 32'(full), 32'd1);
    for (int i = 0; i < 3; i++) step(1'b1, 16'h02E0 + 16'(i), 1'b0, 1'b0);
    check("ovf_drop", 32'(drop_cnt), 32'd3);
    check("ovf_count", 32'(count), 32'd8);
    check("ovf_head", 32'(D_pop), 32'h0200);

    // Full with simultaneous hit+pop: 0200 leaves, 02AA enters at the tail.
    step(1'b1, 16'h02AA, 1'b1, 1'b0);
    check("fullpp_count", 32'(count), 32'd8);
    check("fullpp_full", 32'(full), 32'd1);
    check("fullpp_drop", 32'(drop_cnt), 32'd3);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain%0d_dpop", i), 32'(D_pop),
            (i < 7) ? 32'(16'h0201 + 16'(i)) : 32'h02AA);
      step(1'b0, 16'h0, 1'b1, 1'b0);
    end
    check("drain_pndng", 32'(pndng), 32'd0);
    check("drain_full", 32'(full), 32'd0);

    // Broadcast.
    step(1'b1, 16'hFF55, 1'b0, 1'b0);
`ifdef BUS_RX_BCAST_EN
    check("bcast_pndng", 32'(pndng), 32'd1);
    check("bcast_dpop", 32'(D_pop), 32'hFF55);
    step(1'b0, 16'h0, 1'b1, 1'b0);
`else
    check("bcast_pndng", 32'(pndng), 32'd0);
`endif
    check("bcast_misroute", 32'(misroute), 32'd0);
    check("bcast_drop", 32'(drop_cnt), 32'd3);

    // Misroute, then reset mid-traffic.
    step(1'b1, 16'h0700, 1'b0, 1'b0);
    check("misroute_set", 32'(misroute), 32'd1);
    check("misroute_count", 32'(count), 32'd0);
    step(1'b1, 16'h0241, 1'b0, 1'b0);
    step(1'b1, 16'h0242, 1'b0, 1'b0);
    step(1'b1, 16'h0243, 1'b0, 1'b0);
    check("prereset_count", 32'(count), 32'd3);
    check("misroute_sticky", 32'(misroute), 32'd1);
    step(1'b1, 16'h0244, 1'b1, 1'b1);
    check_reset_state("midreset");

    // Pointer wrap with count kept between 1 and 3.
    q.delete();
    for (int i = 0; i < 20; i++) begin
      do_pop = (q.size() >= 3) || ((q.size() >= 2) && (i % 3 == 0));
      if (q.size() > 0)
        check($sformatf("wrap%0d_head", i), 32'(D_pop), 32'(q[0]));
      step(1'b1, 16'h0230 + 16'(i), do_pop, 1'b0);
      if (do_pop) void'(q.pop_front());
      q.push_back(16'h0230 + 16'(i));
      check($sformatf("wrap%0d_count", i), 32'(count), 32'(q.size()));
    end
    while (q.size() > 0) begin
      check("wrapdrain_head", 32'(D_pop), 32'(q[0]));
      step(1'b0, 16'h0, 1'b1, 1'b0);
      void'(q.pop_front());
    end
    check("wrap_pndng", 32'(pndng), 32'd0);
    check("wrap_drop", 32'(drop_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
